rmcp_multi_bw: RTL and testbench
================================

# rmcp_multi_bw

Parametrised cyclic-prefix remover for the OFDM receive chain, between frame synchronisation and the FFT. It supersedes the fixed 1024/32 remover with a run-time FFT size and CP length selected by the bandwidth index, and an adjustable FFT-window advance into the CP. It also adds ival-driven stalling, end-of-symbol marking and mid-frame resynchronisation with error flagging.

## Interface
Parameters:
- pDAT_W, 12, I/Q sample width
- pNFFT_MAX, 1024, FFT size at index_bw = 0; sizes for other modes derive from it
- pCP_MAX, 32, CP length at index_bw = 0
- pSB_NUM, 50, OFDM symbols per frame
- pFC_W, 7, count_frame width; must satisfy 2^pFC_W ≥ pSB_NUM

Ports:
- clk  in  1  sample clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- isop  in  1  frame start; marks the first CP sample of symbol 0; qualified by ival
- ival  in  1  input sample valid
- in_real_data / in_imag_data  in  pDAT_W  input I/Q
- index_bw  in  3  mode select:
  - 0 → N = pNFFT_MAX, CP = pCP_MAX
  - 1 → N/2, CP/2
  - 2 → N/4, CP/4
  - 3 → N/8, CP/8
  - 4–7 → reserved, treated as 0
- cp_shift  in  6  window advance into the CP, in samples, unsigned
- osop  out  1  first output sample of each symbol
- oeop  out  1  last output sample of each symbol
- oval  out  1  output sample valid
- out_real_data / out_imag_data  out  pDAT_W  output I/Q
- count_frame  out  pFC_W  index of the symbol currently on the output
- oerr  out  1  one-cycle pulse on resynchronisation abort

## Operation
- **Mode latching.** On an accepted isop (isop & ival), latch N, CP and S = min(cp_shift, CP). These values hold until the next accepted isop. Changes on index_bw or cp_shift mid-frame have no effect.
- **FSM states:** IDLE, SKIP, PASS, TAIL.
  - IDLE → SKIP on accepted isop. That sample is sample 0 of symbol 0.
  - SKIP discards the first CP−S samples of the symbol. If CP−S = 0, go directly to PASS, and the isop sample is itself the first output sample.
  - PASS forwards N samples. osop is on the first; oeop is on the N-th.
  - TAIL discards the remaining S samples. If S = 0, skip TAIL.
  - After TAIL: if the symbol index is below pSB_NUM−1, increment it and go to SKIP; otherwise go to IDLE.
- **Counters.** One sample counter, wide enough for pNFFT_MAX + pCP_MAX − 1; it resets at every symbol boundary. One symbol counter, pFC_W bits.
- **Stalling.** Counters and FSM advance only on ival = 1. While ival = 0, oval = osop = oeop = 0.
- **Mid-frame resync.** An accepted isop while not in IDLE:
  - pulses oerr for one cycle;
  - forces oval/osop/oeop low for the aborted sample;
  - relatches the mode;
  - restarts at symbol 0, sample 0, in the same cycle. The aborted symbol never receives oeop.
- **Data path.** Out-of-window samples are dropped. Output data is registered and holds its last value while oval = 0.
- **count_frame** equals the symbol index of the current output sample. It updates together with osop and resets to 0 in IDLE.

## Timing
- Latency: an input sample accepted at cycle t appears on the outputs at t+1. All outputs are registered.
- Reset (rst = 0, asynchronous): FSM = IDLE. All outputs reset to 0: oval, osop, oeop, oerr, count_frame, out_real_data, out_imag_data.
- Per symbol, N+CP accepted input samples give exactly N oval cycles.
- Throughput: one sample per clock, with no bubbles inside the window.
- osop and oeop coincide only if N = 1, which is not a legal configuration.
- isop arriving while ival = 0 is ignored.
- Release of reset mid-stream: the block stays in IDLE until the next accepted isop.

## Test plan
- **Mode 0, cp_shift = 0.** isop then 50×1056 contiguous ramp samples (value = input index) → per symbol k:
  - 1024 oval, first data = k·1056 + 32;
  - osop and oeop once each;
  - count_frame 0..49, then IDLE.
- **Mode 2 (N = 256, CP = 8).** Three cases:
  - cp_shift = 5 → first output is sample 3 of each 264-sample symbol, and 5 tail samples are dropped;
  - cp_shift = 20 → clamped to 8; the isop sample is the first output sample;
  - index_bw = 6 → behaves as mode 0.
- **Random ival.** ival ~50% random duty in mode 1 → output equals the gap-free reference sequence; no osop/oeop while oval = 0.
- **Mid-frame resync.** isop at sample 400 of symbol 3 →
  - oerr pulses once;
  - no oeop for symbol 3;
  - a new osop appears after CP−S samples, with count_frame = 0;
  - the mode latched at the second isop is used.
- **Mode change mid-frame.** index_bw switched 0→3 during symbol 10 → the frame completes in mode 0; after the next isop, each symbol gives 128 outputs per 132 inputs.
- **Reset mid-PASS.** Assert rst = 0 for 1 cycle in the middle of PASS → all outputs are 0 asynchronously, the FSM is IDLE, and there is no output until the next isop.

Source files
------------

// File: rtl/rmcp_multi_bw.sv
// rmcp_multi_bw: cyclic-prefix remover with run-time FFT size / CP length, window advance,
// ival stalling, symbol framing and mid-frame resynchronisation.
module rmcp_multi_bw #(
    parameter int pDAT_W    = 12,
    parameter int pNFFT_MAX = 1024,
    parameter int pCP_MAX   = 32,
    parameter int pSB_NUM   = 50,
    parameter int pFC_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isop,
    input  logic              ival,
    input  logic [pDAT_W-1:0] in_real_data,
    input  logic [pDAT_W-1:0] in_imag_data,
    input  logic [2:0]        index_bw,
    input  logic [5:0]        cp_shift,
    output logic              osop,
    output logic              oeop,
    output logic              oval,
    output logic [pDAT_W-1:0] out_real_data,
    output logic [pDAT_W-1:0] out_imag_data,
    output logic [pFC_W-1:0]  count_frame,
    output logic              oerr
);
    localparam int CW0 = $clog2(pNFFT_MAX + pCP_MAX);
    localparam int CW  = CW0 < 7 ? 7 : CW0;

    typedef enum logic [1:0] {IDLE, SKIP, PASS, TAIL} state_t;

    state_t           st_q, st_d;
    logic [CW-1:0]    n_q, cp_q, s_q, cnt_q;
    logic [CW-1:0]    n_c, cp_c, s_c, hd_c, pos_c, cnt_d, n_new, cp_new, sh_w;
    logic [pFC_W-1:0] sym_q, sym_c, sym_d, cf_q, cf_d;
    logic [1:0]       sel;
    logic             acc, resync, go, in_pass, emit, first, last, last_out;
    logic             oval_q, osop_q, oeop_q, oerr_q;
    logic [pDAT_W-1:0] re_q, im_q;

    // An accepted isop overrides the latched mode and position for its own sample,
    // so the restart takes effect in the same cycle.
    always_comb begin
        sel      = index_bw[2] ? 2'd0 : index_bw[1:0];
        n_new    = CW'(pNFFT_MAX >> sel);
        cp_new   = CW'(pCP_MAX >> sel);
        sh_w     = CW'(cp_shift);
        acc      = isop & ival;
        resync   = acc & (st_q != IDLE);
        go       = ival & (isop | (st_q != IDLE));
        n_c      = acc ? n_new : n_q;
        cp_c     = acc ? cp_new : cp_q;
        s_c      = acc ? (sh_w > cp_new ? cp_new : sh_w) : s_q;
        hd_c     = cp_c - s_c;
        pos_c    = acc ? '0 : cnt_q;
        sym_c    = acc ? '0 : sym_q;
        in_pass  = acc ? (hd_c == '0) : (st_q == PASS);
        emit     = go & in_pass & ~resync;
        first    = pos_c == hd_c;
        last_out = pos_c == hd_c + n_c - CW'(1);
        last     = pos_c == cp_c + n_c - CW'(1);
        cnt_d    = last ? '0 : pos_c + CW'(1);
        sym_d    = last ? sym_c + pFC_W'(1) : sym_c;
        st_d     = (last && sym_c == pFC_W'(pSB_NUM - 1)) ? IDLE :
                   cnt_d < hd_c ? SKIP : cnt_d < hd_c + n_c ? PASS : TAIL;
        cf_d     = acc ? '0 : (emit & first) ? sym_c : (st_q == IDLE) ? '0 : cf_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= IDLE;
            n_q    <= '0;
            cp_q   <= '0;
            s_q    <= '0;
            cnt_q  <= '0;
            sym_q  <= '0;
            cf_q   <= '0;
            oval_q <= 1'b0;
            osop_q <= 1'b0;
            oeop_q <= 1'b0;
            oerr_q <= 1'b0;
            re_q   <= '0;
            im_q   <= '0;
        end else begin
            if (acc) begin
                n_q  <= n_new;
                cp_q <= cp_new;
                s_q  <= s_c;
            end
            if (go) begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                sym_q <= sym_d;
            end
            if (emit) begin
                re_q <= in_real_data;
                im_q <= in_imag_data;
            end
            cf_q   <= cf_d;
            oval_q <= emit;
            osop_q <= emit & first;
            oeop_q <= emit & last_out;
            oerr_q <= resync;
        end
    end

    assign oval          = oval_q;
    assign osop          = osop_q;
    assign oeop          = oeop_q;
    assign oerr          = oerr_q;
    assign out_real_data = re_q;
    assign out_imag_data = im_q;
    assign count_frame   = cf_q;
endmodule

// File: tb/tb_rmcp_multi_bw.sv
// tb_rmcp_multi_bw: scoreboard bench for the multi-bandwidth cyclic-prefix remover.
module tb_rmcp_multi_bw;
    localparam int DW = 12, NMAX = 1024, CPMAX = 32, SB = 50, FCW = 7;

    logic clk = 0, rst = 1, isop = 0, ival = 0;
    logic [DW-1:0] ire = 0, iim = 0;
    logic [2:0] bw = 0;
    logic [5:0] sh = 0;
    logic osop, oeop, oval, oerr;
    logic [DW-1:0] ore, oim;
    logic [FCW-1:0] cf;

    rmcp_multi_bw #(.pDAT_W(DW), .pNFFT_MAX(NMAX), .pCP_MAX(CPMAX), .pSB_NUM(SB), .pFC_W(FCW)) dut (
        .clk(clk), .rst(rst), .isop(isop), .ival(ival),
        .in_real_data(ire), .in_imag_data(iim), .index_bw(bw), .cp_shift(sh),
        .osop(osop), .oeop(oeop), .oval(oval),
        .out_real_data(ore), .out_imag_data(oim), .count_frame(cf), .oerr(oerr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic sop;
        logic eop;
        logic [FCW-1:0] cf;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_fail = 0, n_err = 0, n_oval = 0;
    int idx = 0;
    bit m_act = 0;
    int m_n, m_cp, m_s, m_pos, m_sym;
    logic [DW-1:0] last_re = 0, last_im = 0;

    always @(negedge clk) begin
        exp_t e, g;
        if (rst) begin
            if (oerr) n_err++;
            g = '{re: ore, im: oim, sop: osop, eop: oeop, cf: cf};
            n_chk++;
            if (oval) begin
                n_oval++;
                last_re = ore;
                last_im = oim;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output got=%h required=no output", g);
                end else begin
                    e = q.pop_front();
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL sample got re=%h im=%h sop=%b eop=%b cf=%0d required re=%h im=%h sop=%b eop=%b cf=%0d",
                                 ore, oim, osop, oeop, cf, e.re, e.im, e.sop, e.eop, e.cf);
                    end
                end
            end else if ({osop, oeop, ore, oim} !== {2'b00, last_re, last_im}) begin
                n_fail++;
                $display("FAIL idle_hold got sop=%b eop=%b re=%h im=%h required 0 0 %h %h",
                         osop, oeop, ore, oim, last_re, last_im);
            end
        end
    end

    task automatic drive(input bit sop, input bit val);
        exp_t e;
        bit abort;
        int sel, hd;
        logic [DW-1:0] d;
        d = idx[DW-1:0];
        isop = sop;
        ival = val;
        ire = val ? d : DW'($urandom);
        iim = val ? ~d : DW'($urandom);
        if (val) begin
            idx++;
            abort = 0;
            if (sop) begin
                abort = m_act;
                sel = (bw > 3) ? 0 : int'(bw);
                m_n = NMAX >> sel;
                m_cp = CPMAX >> sel;
                m_s = (int'(sh) > m_cp) ? m_cp : int'(sh);
                m_pos = 0;
                m_sym = 0;
                m_act = 1;
            end
            if (m_act) begin
                hd = m_cp - m_s;
                if (!abort && m_pos >= hd && m_pos < hd + m_n) begin
                    e.re = d;
                    e.im = ~d;
                    e.sop = (m_pos == hd);
                    e.eop = (m_pos == hd + m_n - 1);
                    e.cf = m_sym[FCW-1:0];
                    q.push_back(e);
                end
                m_pos++;
                if (m_pos == m_n + m_cp) begin
                    m_pos = 0;
                    m_sym++;
                    if (m_sym == SB) m_act = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        isop = 0;
        ival = 0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_leftover got=%0d missing outputs required=0", name, q.size());
        end
        q.delete();
    endtask

    task automatic do_reset(input string name);
        isop = 0;
        ival = 0;
        rst = 0;
        #1;
        n_chk++;
        if ({oval, osop, oeop, oerr, cf, ore, oim} !== '0) begin
            n_fail++;
            $display("FAIL %s_reset got oval=%b sop=%b eop=%b err=%b cf=%0d re=%h im=%h required all 0",
                     name, oval, osop, oeop, oerr, cf, ore, oim);
        end
        q.delete();
        m_act = 0;
        idx = 0;
        last_re = 0;
        last_im = 0;
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        do_reset("initial");
        for (int i = 0; i < 40; i++) drive(0, 1);
        drain("no_isop");
    endtask

    task automatic test_mode0_full_and_change();
        int o0, e0;
        bw = 0;
        sh = 0;
        o0 = n_oval;
        e0 = n_err;
        drive(1, 1);
        for (int i = 1; i < SB * 1056; i++) begin
            if (i == 10 * 1056 + 500) begin
                bw = 3;
                sh = 2;
            end
            drive(0, 1);
        end
        drain("mode0");
        n_chk++;
        if (n_oval - o0 != SB * 1024) begin
            n_fail++;
            $display("FAIL mode0_count got=%0d required=%0d", n_oval - o0, SB * 1024);
        end
        n_chk++;
        if (cf !== 0 || n_err != e0) begin
            n_fail++;
            $display("FAIL mode0_idle got cf=%0d err=%0d required cf=0 err=0", cf, n_err - e0);
        end
        for (int i = 0; i < 20; i++) drive(0, 1);
        sh = 0;
        o0 = n_oval;
        drive(1, 1);
        for (int i = 1; i < 2 * 132; i++) drive(0, 1);
        drain("mode3");
        n_chk++;
        if (n_oval - o0 != 256) begin
            n_fail++;
            $display("FAIL mode3_count got=%0d required=256", n_oval - o0);
        end
        do_reset("mode3");
    endtask

    task automatic test_mode2();
        int o0, syms, per;
        logic [2:0] bws[3] = '{3'd2, 3'd2, 3'd6};
        logic [5:0] shs[3] = '{6'd5, 6'd20, 6'd0};
        for (int c = 0; c < 3; c++) begin
            bw = bws[c];
            sh = shs[c];
            syms = (c == 2) ? 1 : 2;
            per = (c == 2) ? 1056 : 264;
            o0 = n_oval;
            drive(1, 1);
            n_chk++;
            if (c == 1 && (oval !== 1 || osop !== 1 || ore !== 0)) begin
                n_fail++;
                $display("FAIL clamp_first got oval=%b sop=%b re=%h required 1 1 000", oval, osop, ore);
            end
            for (int i = 1; i < syms * per; i++) drive(0, 1);
            drain("mode2");
            n_chk++;
            if (n_oval - o0 != syms * (per == 264 ? 256 : 1024)) begin
                n_fail++;
                $display("FAIL mode2_case%0d_count got=%0d required=%0d", c, n_oval - o0, syms * (per == 264 ? 256 : 1024));
            end
            do_reset("mode2");
        end
    endtask

    task automatic test_random_ival();
        int o0, v;
        bw = 1;
        sh = 3;
        o0 = n_oval;
        drive(1, 1);
        v = 1;
        for (int i = 0; i < 20000 && v < 2 * 528; i++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            drive(0, b);
            if (b) v++;
        end
        drain("random");
        n_chk++;
        if (n_oval - o0 != 1024) begin
            n_fail++;
            $display("FAIL random_count got=%0d required=1024", n_oval - o0);
        end
        do_reset("random");
    endtask

    task automatic test_resync();
        int o0, e0;
        bw = 1;
        sh = 4;
        o0 = n_oval;
        e0 = n_err;
        drive(1, 1);
        for (int i = 1; i < 3 * 528 + 400; i++) drive(0, 1);
        bw = 2;
        sh = 5;
        drive(1, 1);
        n_chk++;
        if (oerr !== 1 || oval !== 0 || oeop !== 0) begin
            n_fail++;
            $display("FAIL resync_abort got err=%b oval=%b eop=%b required 1 0 0", oerr, oval, oeop);
        end
        bw = 0;
        sh = 0;
        for (int i = 1; i < 2 * 264; i++) drive(0, 1);
        drain("resync");
        n_chk++;
        if (n_err - e0 != 1) begin
            n_fail++;
            $display("FAIL resync_err_count got=%0d required=1", n_err - e0);
        end
        n_chk++;
        if (n_oval - o0 != 3 * 512 + 388 + 2 * 256) begin
            n_fail++;
            $display("FAIL resync_count got=%0d required=%0d", n_oval - o0, 3 * 512 + 388 + 2 * 256);
        end
        do_reset("resync");
    endtask

    task automatic test_reset_mid_pass();
        int o0;
        bw = 0;
        sh = 0;
        drive(1, 1);
        for (int i = 1; i < 100; i++) drive(0, 1);
        n_chk++;
        if (oval !== 1) begin
            n_fail++;
            $display("FAIL mid_pass_active got oval=%b required=1", oval);
        end
        do_reset("mid_pass");
        for (int i = 0; i < 300; i++) drive(0, 1);
        drain("after_reset");
        o0 = n_oval;
        drive(1, 1);
        for (int i = 1; i < 1056; i++) drive(0, 1);
        drain("restart");
        n_chk++;
        if (n_oval - o0 != 1024) begin
            n_fail++;
            $display("FAIL restart_count got=%0d required=1024", n_oval - o0);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_full_and_change();
        test_mode2();
        test_random_ival();
        test_resync();
        test_reset_mid_pass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
